// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths used by
// the APB master and the 8-bit APB slave memory block.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB master: synchronous clear/increment with a
// terminal-count flag raised once TC-1 waiting cycles have already elapsed.
module apb_wait_timer #(
  parameter int unsigned TC = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CW = (TC < 2) ? 1 : $clog2(TC + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag the cycle whose low pready would be the TC-th consecutive wait.
  assign tc_o = (count_q == CW'(TC - 1));

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP/ACCESS sequencing, registered
// bus and response outputs. Optional wait timeout under APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be at least 1");
  end

  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept;
  logic              abort;

`ifdef APB_MASTER_TIMEOUT_EN
  logic tmo_tc;

  apb_wait_timer #(
    .TC(TIMEOUT)
  ) u_wait_timer (
    .clk_i (pclk),
    .rst_i (preset),
    .clr_i (state_q == SETUP),
    .inc_i ((state_q == ACCESS) && !pready),
    .tc_o  (tmo_tc)
  );

  assign abort = (state_q == ACCESS) && !pready && tmo_tc;
`else
  assign abort = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          if (!pwrite_q) begin
            rsp_rdata_d = prdata;
          end
          // A command accepted here chains straight into its SETUP phase.
          state_d = accept ? SETUP : IDLE;
        end else if (abort) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (default build): timestamp-based transfer model
// checked every cycle, plus literal expectations per scenario.
module tb_apb_master;

  logic       pclk;
  logic       preset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  apb_master #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(4)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc = cyc + 1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transfer accepted at edge a is in SETUP during cycle a and in
  // ACCESS from cycle a+1 until the edge that samples pready high.
  bit          m_ok = 1'b0;
  bit          m_busy = 1'b0;
  int unsigned m_acc = 0;
  bit          m_wr = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rdata = '0;
  bit          m_rsp_pend = 1'b0;
  int unsigned m_rsp_cyc = 0;

  int unsigned rsp_cnt = 0;
  int unsigned last_rsp_cyc = 0;
  int unsigned prev_rsp_cyc = 0;
  int unsigned pen_cnt = 0;
  int unsigned psel_low_cnt = 0;

  always @(negedge pclk) begin
    bit in_access;
    bit exp_ready;
    in_access = m_busy && (cyc > m_acc);
    exp_ready = !m_busy || (in_access && pready);
    if (m_ok) begin
      chk("psel", {31'd0, psel}, {31'd0, m_busy});
      chk("penable", {31'd0, penable}, {31'd0, in_access});
      chk("pwrite", {31'd0, pwrite}, {31'd0, m_wr});
      chk("paddr", {24'd0, paddr}, {24'd0, m_addr});
      chk("pwdata", {24'd0, pwdata}, {24'd0, m_wdata});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (m_rsp_pend && (m_rsp_cyc == cyc))});
      chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, m_rdata});
      chk("rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
      if (rsp_valid === 1'b1) begin
        rsp_cnt      = rsp_cnt + 1;
        prev_rsp_cyc = last_rsp_cyc;
        last_rsp_cyc = cyc;
      end
      if (penable === 1'b1) pen_cnt = pen_cnt + 1;
      if (psel !== 1'b1) psel_low_cnt = psel_low_cnt + 1;
    end
    if (preset) begin
      m_ok       = 1'b1;
      m_busy     = 1'b0;
      m_wr       = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_rdata    = '0;
      m_rsp_pend = 1'b0;
    end else if (m_ok) begin
      if (in_access && pready) begin
        m_rsp_pend = 1'b1;
        m_rsp_cyc  = cyc + 1;
        if (!m_wr) m_rdata = prdata;
        m_busy = 1'b0;
      end
      if (cmd_valid && exp_ready) begin
        m_busy  = 1'b1;
        m_acc   = cyc + 1;
        m_wr    = cmd_write;
        m_addr  = cmd_addr;
        m_wdata = cmd_wdata;
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Present a command and wait (bounded) for the edge that accepts it.
  task automatic issue(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                       input bit hold, output int unsigned acc);
    bit got;
    bit rdy;
    got       = 1'b0;
    acc       = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge pclk);
      rdy = cmd_ready;
      @(posedge pclk);
      #1;
      if (rdy) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    if (!hold) cmd_valid = 1'b0;
    if (!got) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  initial begin
    int unsigned a1;
    int unsigned a2;
    int unsigned r0;
    int unsigned p0;
    int unsigned s0;

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = 8'h00;
    pready    = 1'b1;
    idle(2);
    chk("reset_psel", {31'd0, psel}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    preset = 1'b0;
    idle(1);

    // Write 0x03/0xA5, zero wait states; prdata must not reach rsp_rdata.
    prdata = 8'h77;
    r0 = rsp_cnt;
    issue(1'b1, 8'h03, 8'hA5, 1'b0, a1);
    idle(4);
    chk("wr_rsp_count", rsp_cnt - r0, 32'd1);
    chk("wr_latency", last_rsp_cyc - a1, 32'd2);
    chk("wr_rdata_kept", {24'd0, rsp_rdata}, 32'h00);

    // Read 0x05 with three wait states.
    pready = 1'b0;
    prdata = 8'hEE;
    r0 = rsp_cnt;
    p0 = pen_cnt;
    issue(1'b0, 8'h05, 8'h00, 1'b0, a1);
    idle(4);
    pready = 1'b1;
    prdata = 8'h5A;
    idle(3);
    chk("rd_access_cycles", pen_cnt - p0, 32'd4);
    chk("rd_rsp_count", rsp_cnt - r0, 32'd1);
    chk("rd_rdata", {24'd0, rsp_rdata}, 32'h5A);
    chk("model_rdata", {24'd0, m_rdata}, 32'h5A);

    // Back-to-back write 0x01/0x11 then read 0x01.
    prdata = 8'h11;
    r0 = rsp_cnt;
    issue(1'b1, 8'h01, 8'h11, 1'b1, a1);
    s0 = psel_low_cnt;
    issue(1'b0, 8'h01, 8'h00, 1'b0, a2);
    chk("b2b_psel_gap", psel_low_cnt - s0, 32'd0);
    chk("b2b_accept_gap", a2 - a1, 32'd2);
    idle(5);
    chk("b2b_rsp_count", rsp_cnt - r0, 32'd2);
    chk("b2b_rsp_spacing", last_rsp_cyc - prev_rsp_cyc, 32'd2);
    chk("b2b_rdata", {24'd0, rsp_rdata}, 32'h11);

    // Reset while ACCESS waits on pready.
    pready = 1'b0;
    r0 = rsp_cnt;
    issue(1'b0, 8'h07, 8'h00, 1'b0, a1);
    idle(2);
    preset = 1'b1;
    idle(1);
    preset = 1'b0;
    chk("rst_mid_psel", {31'd0, psel}, 32'd0);
    chk("rst_mid_penable", {31'd0, penable}, 32'd0);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    pready = 1'b1;
    idle(4);
    chk("rst_mid_no_rsp", rsp_cnt - r0, 32'd0);

    // No timeout in this build: ACCESS holds for 50 low-pready cycles.
    pready = 1'b0;
    r0 = rsp_cnt;
    p0 = pen_cnt;
    issue(1'b0, 8'h09, 8'h00, 1'b0, a1);
    idle(51);
    chk("wait50_no_rsp", rsp_cnt - r0, 32'd0);
    chk("wait50_access", pen_cnt - p0, 32'd50);
    pready = 1'b1;
    prdata = 8'h3C;
    idle(3);
    chk("wait50_rsp_count", rsp_cnt - r0, 32'd1);
    chk("wait50_rdata", {24'd0, rsp_rdata}, 32'h3C);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
